chacha20_block_core: RTL and testbench
======================================

# chacha20_block_core

Computes one 512-bit ChaCha20 keystream block (RFC 8439 block function) from a 256-bit key, 96-bit nonce and the 32-bit block counter supplied by `Block_Counter`. It sits directly downstream of `Block_Counter`: it consumes its `Block` word and produces the `blockready` pulse and `blocksproduced` count that `Block_Counter` uses to advance. The output keystream feeds the XOR/encrypt stage and the Poly1305 key generator.

## Interface
- `ROUNDS`, 20: total rounds (even; 10 double rounds).
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request one block; sampled only in IDLE.
- `key`  in  256  key; word i = `key[32*i+31:32*i]`, little-endian word order.
- `nonce`  in  96  nonce; word i = `nonce[32*i+31:32*i]`.
- `counter`  in  32  block counter (from `Block_Counter.Block`).
- `busy`  out  1  high from start acceptance through the FINAL cycle.
- `blockready`  out  1  one-cycle pulse: `keystream` is valid.
- `keystream`  out  512  output block; state word i = `keystream[32*i+31:32*i]`.
- `blocksproduced`  out  32  count of completed blocks, wraps mod 2^32.

## Operation
- Clock `clk`; reset is asynchronous and active-low via `rst_n`.
- Reset values: state IDLE, `busy`=0, `blockready`=0, `keystream`=0, `blocksproduced`=0, round counter 0, internal init/working state 0.
- States: IDLE, ROUND, FINAL.
- IDLE: on `start`=1 capture init state = {C0..C3, key[0..7], counter, nonce[0..2]} into both init and working registers; round counter <= 0; go ROUND. `start`=0: stay.
- ROUND: one round per cycle via 4 parallel quarter-rounds. Even round count: column round (0,4,8,12)(1,5,9,13)(2,6,10,14)(3,7,11,15). Odd: diagonal round (0,5,10,15)(1,6,11,12)(2,7,8,13)(3,4,9,14). Increment counter; after round `ROUNDS-1` go FINAL.
- FINAL: `keystream` <= word-wise (working + init) mod 2^32; `blockready` <= 1; `blocksproduced` <= `blocksproduced`+1; go IDLE.
- `blockready` deasserts on the next edge unconditionally; `keystream` holds until the next FINAL.
- Constants C0..C3 = 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574.
- All additions mod 2^32; rotations 16, 12, 8, 7 left.
- `counter` = 0xFFFFFFFF is used as-is; no carry into nonce, no error flag (overflow is `Block_Counter`'s concern).
- `start` while not IDLE: ignored, no queueing. `key`/`nonce`/`counter` changes after acceptance have no effect on the block in flight.
- `start` in the cycle `blockready`=1 (state IDLE): accepted.
- `rst_n` low mid-block: immediate return to reset values; no `blockready`, partial block discarded.

## Timing
- Acceptance edge E0 → rounds on E1..E20 → FINAL edge E21: `blockready`=1 and `keystream` valid in the cycle after E21; start-to-`blockready` latency 21 cycles (`ROUNDS`+1).
- `busy` high from after E0 through the cycle before `blockready` rises; low when `blockready`=1.
- Back-to-back throughput: one block per 22 cycles.
- `Block_Counter` increments on `blockready` rising edge and updates `Block` one edge later; the upstream controller asserts `start` no earlier than the second cycle after `blockready` to pick up the new counter. This block does not enforce it.

## Structure
- Package `chacha_pkg`: `word_t` (32-bit), `state_t` (16 × `word_t`), constants C0..C3, rotation amounts.
- Sub-module `chacha_quarter_round`: purely combinational (a,b,c,d in → a,b,c,d out), instantiated 4×; the two round index patterns muxed in front by round parity.
- Top holds FSM, round counter (5 bits), init/working state, output registers.

## Test plan
- RFC 8439 §2.3.2: key 0x00..0x1f byte-sequential, nonce bytes 00 00 00 09 00 00 00 4a 00 00 00 00, counter 1, `start` → `blockready` exactly 21 cycles later, word0 = 0xe4e7f110, word15 = 0x4e3c50a2, full block matches RFC, `blocksproduced`=1.
- All-zero key/nonce, counter 0 → word0 = 0xade0b876 (RFC §A.1 test 1); then counter 1 → word0 = 0xbee7079f (test 2).
- `start` held high during ROUND, and key/counter changed mid-block → exactly one `blockready` per 22 cycles, output matches values captured at acceptance.
- `rst_n` pulsed low at round 10 → all outputs 0 immediately, no `blockready`; a fresh `start` then yields a correct block.
- Counter 0xFFFFFFFF → result matches golden model with word12 = 0xFFFFFFFF, nonce words unchanged; `blocksproduced` preset to wrap from 0xFFFFFFFF to 0.
- Integrated with `Block_Counter`, `start` two cycles after each `blockready` → consecutive blocks use counters 1, 2, 3 and match the golden model.

Source files
------------

// File: rtl/chacha_pkg.sv
// Shared types and constants for the ChaCha20 block function.
// Latency: n/a (types, constants and a rotate helper only).
// Backpressure: n/a.
package chacha_pkg;

  typedef logic [31:0]       word_t;
  typedef logic [15:0][31:0] state_t;  // word i sits at bits [32*i+31:32*i]

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2
  } fsm_t;

  // "expand 32-byte k" as little-endian words
  localparam word_t C0 = 32'h61707865;
  localparam word_t C1 = 32'h3320646e;
  localparam word_t C2 = 32'h79622d32;
  localparam word_t C3 = 32'h6b206574;

  localparam int unsigned ROT_A = 16;
  localparam int unsigned ROT_B = 12;
  localparam int unsigned ROT_C = 8;
  localparam int unsigned ROT_D = 7;

  function automatic word_t rotl(input word_t x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

endpackage

// File: rtl/chacha_quarter_round.sv
// One ChaCha quarter-round on four words.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input.
module chacha_quarter_round
  import chacha_pkg::*;
(
  input  word_t a,
  input  word_t b,
  input  word_t c,
  input  word_t d,
  output word_t a_n,
  output word_t b_n,
  output word_t c_n,
  output word_t d_n
);

  word_t a1, b1, c1, d1;

  // add / xor / rotate ladder; each stage feeds the next
  always_comb begin
    a1  = a + b;
    d1  = rotl(d ^ a1, ROT_A);
    c1  = c + d1;
    b1  = rotl(b ^ c1, ROT_B);
    a_n = a1 + b1;
    d_n = rotl(d1 ^ a_n, ROT_C);
    c_n = c1 + d_n;
    b_n = rotl(b1 ^ c_n, ROT_D);
  end

endmodule

// File: rtl/chacha20_block_core.sv
// ChaCha20 block function: one 512-bit keystream block per request.
// Latency: start accepted to blockready is ROUNDS+1 cycles; one round per cycle.
// Backpressure: none; start is ignored while busy, nothing is queued.
module chacha20_block_core
  import chacha_pkg::*;
#(
  parameter int ROUNDS = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] key,
  input  logic [95:0]  nonce,
  input  logic [31:0]  counter,
  output logic         busy,
  output logic         blockready,
  output logic [511:0] keystream,
  output logic [31:0]  blocksproduced
);

  localparam logic [4:0] LAST_RND = 5'(ROUNDS - 1);

  fsm_t        state_q, state_d;
  logic [4:0]  rnd_q;
  state_t      init_q, work_q, ks_q;
  state_t      init_w, round_w, sum_w;
  logic        blockready_q;
  logic [31:0] produced_q;

  word_t qa [4];
  word_t qb [4];
  word_t qc [4];
  word_t qd [4];
  word_t ra [4];
  word_t rb [4];
  word_t rc [4];
  word_t rd [4];

  // initial state: constants, key, counter, nonce (word 0 at the LSBs)
  assign init_w = {nonce, counter, key, C3, C2, C1, C0};

  // four quarter-rounds; odd rounds walk the diagonals instead of the columns
  for (genvar q = 0; q < 4; q++) begin : g_qr
    assign qa[q] = work_q[q];
    assign qb[q] = rnd_q[0] ? work_q[4 + ((q + 1) % 4)]  : work_q[4 + q];
    assign qc[q] = rnd_q[0] ? work_q[8 + ((q + 2) % 4)]  : work_q[8 + q];
    assign qd[q] = rnd_q[0] ? work_q[12 + ((q + 3) % 4)] : work_q[12 + q];

    chacha_quarter_round u_qr (
      .a   (qa[q]),
      .b   (qb[q]),
      .c   (qc[q]),
      .d   (qd[q]),
      .a_n (ra[q]),
      .b_n (rb[q]),
      .c_n (rc[q]),
      .d_n (rd[q])
    );
  end

  // scatter results back: row j of a diagonal round came from quarter-round (j-row) mod 4
  for (genvar j = 0; j < 4; j++) begin : g_wb
    assign round_w[j]      = ra[j];
    assign round_w[4 + j]  = rnd_q[0] ? rb[(j + 3) % 4] : rb[j];
    assign round_w[8 + j]  = rnd_q[0] ? rc[(j + 2) % 4] : rc[j];
    assign round_w[12 + j] = rnd_q[0] ? rd[(j + 1) % 4] : rd[j];
  end

  // feed-forward: working state plus original input, word by word
  for (genvar i = 0; i < 16; i++) begin : g_sum
    assign sum_w[i] = work_q[i] + init_q[i];
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ROUND;
      S_ROUND: if (rnd_q == LAST_RND) state_d = S_FINAL;
      S_FINAL: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q != S_IDLE);
  end

  // datapath: capture on accept, one round per cycle, publish in FINAL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q       <= '0;
      work_q       <= '0;
      rnd_q        <= '0;
      ks_q         <= '0;
      blockready_q <= 1'b0;
      produced_q   <= '0;
    end else begin
      blockready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            init_q <= init_w;
            work_q <= init_w;
            rnd_q  <= '0;
          end
        end
        S_ROUND: begin
          work_q <= round_w;
          rnd_q  <= rnd_q + 5'd1;
        end
        S_FINAL: begin
          ks_q         <= sum_w;
          blockready_q <= 1'b1;
          produced_q   <= produced_q + 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign blockready     = blockready_q;
  assign keystream      = ks_q;
  assign blocksproduced = produced_q;

endmodule

// File: tb/tb_chacha20_block_core.sv
// Directed bench for chacha20_block_core against RFC 8439 vectors and a reference model.
// Latency: checks start-to-blockready of 21 cycles and 22-cycle back-to-back spacing.
// Backpressure: exercises start held high, mid-block input changes and mid-block reset.
module tb_chacha20_block_core;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [255:0] key_r;
  logic [95:0]  nonce_r;
  logic [31:0]  ctr_drv;
  logic [31:0]  counter_in;
  logic         busy;
  logic         blockready;
  logic [511:0] keystream;
  logic [31:0]  blocksproduced;

  logic         use_bc;
  logic [31:0]  blk_ctr;

  int checks;
  int errors;

  chacha20_block_core #(.ROUNDS(20)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .key            (key_r),
    .nonce          (nonce_r),
    .counter        (counter_in),
    .busy           (busy),
    .blockready     (blockready),
    .keystream      (keystream),
    .blocksproduced (blocksproduced)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stand-in for Block_Counter: advances one edge after seeing blockready
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) blk_ctr <= 32'd1;
    else if (blockready) blk_ctr <= blk_ctr + 32'd1;
  end

  always_comb counter_in = use_bc ? blk_ctr : ctr_drv;

  function automatic logic [31:0] rl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // software reference of the block function, table-driven over 8 quarter-rounds
  function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [95:0] n,
                                             input logic [31:0] c);
    logic [31:0] s [16];
    logic [31:0] x [16];
    logic [31:0] a, b, cc, d;
    logic [511:0] r;
    int idx [8][4];
    idx = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
            '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4 + i] = k[32 * i +: 32];
    s[12] = c;
    for (int i = 0; i < 3; i++) s[13 + i] = n[32 * i +: 32];
    x = s;
    for (int dr = 0; dr < 10; dr++) begin
      for (int q = 0; q < 8; q++) begin
        a = x[idx[q][0]]; b = x[idx[q][1]]; cc = x[idx[q][2]]; d = x[idx[q][3]];
        a = a + b;  d = rl(d ^ a, 16);
        cc = cc + d; b = rl(b ^ cc, 12);
        a = a + b;  d = rl(d ^ a, 8);
        cc = cc + d; b = rl(b ^ cc, 7);
        x[idx[q][0]] = a; x[idx[q][1]] = b; x[idx[q][2]] = cc; x[idx[q][3]] = d;
      end
    end
    r = '0;
    for (int i = 0; i < 16; i++) r[32 * i +: 32] = x[i] + s[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // request one block from IDLE; returns latency (0 on timeout), block and busy samples
  task automatic run_block(output int lat, output logic [511:0] ks,
                           output logic busy_e0, output logic busy_rdy);
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    busy_e0  = busy;
    busy_rdy = 1'b1;
    lat      = 0;
    ks       = '0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (blockready) begin
        lat      = n;
        ks       = keystream;
        busy_rdy = busy;
        break;
      end
    end
  endtask

  logic [255:0] rfc_key, zero_key, key2;
  logic [95:0]  rfc_nonce;
  logic [511:0] rfc_ks, ks, exp_ks;
  logic [511:0] kss [2];
  int           p [2];
  int           lat, np, pulses;
  logic         be0, brdy;

  initial begin
    checks = 0; errors = 0;
    rfc_key   = {32'h1f1e1d1c, 32'h1b1a1918, 32'h17161514, 32'h13121110,
                 32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100};
    rfc_nonce = {32'h00000000, 32'h4a000000, 32'h09000000};
    zero_key  = '0;
    key2      = {32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'hfeedface,
                 32'h0badf00d, 32'h13579bdf, 32'h2468ace0, 32'hcafebabe};
    rfc_ks    = {32'h4e3c50a2, 32'he883d0cb, 32'hb94e16de, 32'hd19c12b5,
                 32'ha2028bd9, 32'h05d7c214, 32'h09aa9f07, 32'h466482d2,
                 32'h4e6cd4c3, 32'h9aaa2204, 32'h0368c033, 32'hc7f4d1c7,
                 32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110};

    rst_n = 1'b0; start = 1'b0; use_bc = 1'b0;
    key_r = '0; nonce_r = '0; ctr_drv = '0;
    repeat (2) @(posedge clk);
    #1;
    chk32("rst_busy", 32'(busy), 32'd0);
    chk32("rst_blockready", 32'(blockready), 32'd0);
    chk("rst_keystream", keystream, '0);
    chk32("rst_produced", blocksproduced, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // RFC 8439 2.3.2 block
    key_r = rfc_key; nonce_r = rfc_nonce; ctr_drv = 32'd1;
    run_block(lat, ks, be0, brdy);
    chk32("rfc_latency", 32'(lat), 32'd21);
    chk32("rfc_busy_after_accept", 32'(be0), 32'd1);
    chk32("rfc_busy_at_ready", 32'(brdy), 32'd0);
    chk32("rfc_word0", ks[31:0], 32'he4e7f110);
    chk32("rfc_word15", ks[511:480], 32'h4e3c50a2);
    chk("rfc_block", ks, rfc_ks);
    chk32("rfc_produced", blocksproduced, 32'd1);
    @(posedge clk); #1;
    chk32("ready_one_cycle", 32'(blockready), 32'd0);
    chk("keystream_holds", keystream, rfc_ks);

    // RFC A.1 tests 1 and 2; second start lands in the blockready cycle
    key_r = zero_key; nonce_r = '0; ctr_drv = 32'd0;
    run_block(lat, ks, be0, brdy);
    chk32("a1t1_word0", ks[31:0], 32'hade0b876);
    ctr_drv = 32'd1;
    run_block(lat, ks, be0, brdy);
    chk32("a1t2_latency", 32'(lat), 32'd21);
    chk32("a1t2_word0", ks[31:0], 32'hbee7079f);
    chk32("a1t2_produced", blocksproduced, 32'd3);

    // start held high, key/counter changed mid-block
    key_r = rfc_key; nonce_r = rfc_nonce; ctr_drv = 32'd1;
    np = 0; p[0] = 0; p[1] = 0; kss[0] = '0; kss[1] = '0;
    start = 1'b1;
    for (int n = 1; n <= 70; n++) begin
      @(posedge clk); #1;
      if (n == 5) begin key_r = key2; ctr_drv = 32'd7; end
      if (n == 30) start = 1'b0;
      if (blockready) begin
        if (np < 2) begin p[np] = n; kss[np] = keystream; end
        np++;
      end
    end
    start = 1'b0;
    chk32("held_pulse_count", 32'(np), 32'd2);
    chk32("held_first_at", 32'(p[0]), 32'd22);
    chk32("held_spacing", 32'(p[1] - p[0]), 32'd22);
    chk("held_block0_captured", kss[0], rfc_ks);
    exp_ks = ref_block(key2, rfc_nonce, 32'd7);
    chk("held_block1_new_inputs", kss[1], exp_ks);
    chk32("held_produced", blocksproduced, 32'd5);

    // reset in the middle of a block
    key_r = rfc_key; ctr_drv = 32'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk32("midrst_busy", 32'(busy), 32'd0);
    chk32("midrst_blockready", 32'(blockready), 32'd0);
    chk("midrst_keystream", keystream, '0);
    chk32("midrst_produced", blocksproduced, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (blockready) pulses++;
    end
    chk32("midrst_no_ready", 32'(pulses), 32'd0);

    // counter at all-ones: used as-is, no carry into the nonce
    ctr_drv = 32'hffffffff;
    run_block(lat, ks, be0, brdy);
    chk32("ctrmax_latency", 32'(lat), 32'd21);
    exp_ks = ref_block(rfc_key, rfc_nonce, 32'hffffffff);
    chk("ctrmax_block", ks, exp_ks);
    chk32("ctrmax_produced", blocksproduced, 32'd1);

    // driven by the Block_Counter stand-in, start two cycles after each blockready
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    use_bc = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      run_block(lat, ks, be0, brdy);
      exp_ks = ref_block(rfc_key, rfc_nonce, 32'(k + 1));
      chk($sformatf("bc_block%0d", k + 1), ks, exp_ks);
      repeat (2) begin @(posedge clk); #1; end
    end
    chk32("bc_produced", blocksproduced, 32'd3);
    use_bc = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
